// File: rtl/sd_cmd_ctrl.sv
// SD CMD line sequencer: shifts out one 48-bit command frame, collects and checks
// the card response (none / R48 / R136), then pulses done_o.
//
// state | meaning
// IDLE  | line released, waiting for start_i
// TX    | driving the 48-bit command frame, MSB first
// WAIT  | line released, looking for the response start bit
// RX    | shifting in the remaining response bits
// GAP   | idle cycles with the line released before completion
// DONE  | one-cycle completion pulse
module sd_cmd_ctrl #(
    parameter int NCR_TIMEOUT = 64,
    parameter int NRC_GAP     = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [5:0]   cmd_index_i,
    input  logic [31:0]  cmd_arg_i,
    input  logic [1:0]   resp_type_i,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_en_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [119:0] resp_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         end_err_o,
    output logic         index_err_o
);
    localparam logic [1:0] RESP_NONE = 2'b00;
    localparam logic [1:0] RESP_R48  = 2'b01;
    localparam logic [1:0] RESP_R136 = 2'b10;
    localparam logic [1:0] RESP_R3   = 2'b11;
    localparam logic [7:0] TX_LAST   = 8'd47;
    localparam logic [7:0] RX48_LAST = 8'd46;
    localparam logic [7:0] RX136_LAST = 8'd134;
    localparam logic [7:0] NCR_LOAD  = 8'(NCR_TIMEOUT - 1);
    localparam logic [7:0] NRC_LOAD  = 8'(NRC_GAP - 1);

    typedef enum logic [2:0] {IDLE, TX, WAIT, RX, GAP, DONE} state_t;

    state_t         state, state_nxt;
    logic [7:0]     cnt;
    logic [47:0]    tx_sr;
    logic [126:0]   rx_sr;
    logic [6:0]     crc;
    logic [5:0]     idx;
    logic [1:0]     rtype;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
        logic fb;
        fb = d ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_of(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_en_o  = 1'b0;
        cmd_o     = 1'b1;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            IDLE: if (start_i) state_nxt = TX;
            TX: begin
                cmd_en_o = 1'b1;
                cmd_o    = tx_sr[47];
                busy_o   = 1'b1;
                if (cnt == 8'd0) state_nxt = (rtype == RESP_NONE) ? GAP : WAIT;
            end
            WAIT: begin
                busy_o = 1'b1;
                if (!cmd_i)             state_nxt = RX;
                else if (cnt == 8'd0)   state_nxt = DONE;
            end
            RX: begin
                busy_o = 1'b1;
                if (cnt == 8'd0) state_nxt = GAP;
            end
            GAP: begin
                busy_o = 1'b1;
                if (cnt == 8'd0) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_i) state_nxt = IDLE;
    end

    // Datapath freezes on abort so the error flags keep their last value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt           <= 8'd0;
            tx_sr         <= '1;
            rx_sr         <= '0;
            crc           <= 7'h00;
            idx           <= 6'd0;
            rtype         <= RESP_NONE;
            resp_o        <= '0;
            timeout_err_o <= 1'b0;
            crc_err_o     <= 1'b0;
            end_err_o     <= 1'b0;
            index_err_o   <= 1'b0;
        end else if (!abort_i) begin
            case (state)
                IDLE: if (start_i) begin
                    idx           <= cmd_index_i;
                    rtype         <= resp_type_i;
                    tx_sr         <= {2'b01, cmd_index_i, cmd_arg_i,
                                      crc7_of({2'b01, cmd_index_i, cmd_arg_i}), 1'b1};
                    cnt           <= TX_LAST;
                    resp_o        <= '0;
                    timeout_err_o <= 1'b0;
                    crc_err_o     <= 1'b0;
                    end_err_o     <= 1'b0;
                    index_err_o   <= 1'b0;
                end
                TX: begin
                    tx_sr <= {tx_sr[46:0], 1'b1};
                    if (cnt == 8'd0) cnt <= (rtype == RESP_NONE) ? NRC_LOAD : NCR_LOAD;
                    else             cnt <= cnt - 8'd1;
                end
                WAIT: begin
                    if (!cmd_i) begin
                        cnt   <= (rtype == RESP_R136) ? RX136_LAST : RX48_LAST;
                        rx_sr <= '0;
                        crc   <= 7'h00;
                    end else if (cnt == 8'd0) begin
                        timeout_err_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RX: begin
                    // cnt is the index of the bit being sampled; CRC covers bits 127..8
                    rx_sr <= {rx_sr[125:0], cmd_i};
                    if (cnt >= 8'd8 && cnt <= 8'd127) crc <= crc7_step(crc, cmd_i);
                    if (cnt == 8'd0) begin
                        resp_o      <= (rtype == RESP_R136) ? rx_sr[126:7] : {88'h0, rx_sr[38:7]};
                        end_err_o   <= ~cmd_i;
                        crc_err_o   <= (rtype != RESP_R3) && (crc != rx_sr[6:0]);
                        index_err_o <= (rtype == RESP_R48) && (rx_sr[44:39] != idx);
                        cnt         <= NRC_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                GAP: if (cnt != 8'd0) cnt <= cnt - 8'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Self-checking bench for sd_cmd_ctrl: vector table with a scoreboard queue,
// plus hand-written abort, mid-response reset and start-during-DONE sequences.
module tb_sd_cmd_ctrl;
    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i, abort_i, cmd_i;
    logic [5:0]   cmd_index_i;
    logic [31:0]  cmd_arg_i;
    logic [1:0]   resp_type_i;
    logic         cmd_o, cmd_en_o, busy_o, done_o;
    logic [119:0] resp_o;
    logic         timeout_err_o, crc_err_o, end_err_o, index_err_o;
    logic [3:0]   errs;

    int n_pass = 0;
    int n_total = 0;

    sd_cmd_ctrl #(.NCR_TIMEOUT(64), .NRC_GAP(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .cmd_index_i(cmd_index_i), .cmd_arg_i(cmd_arg_i), .resp_type_i(resp_type_i),
        .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_en_o(cmd_en_o), .busy_o(busy_o),
        .done_o(done_o), .resp_o(resp_o), .timeout_err_o(timeout_err_o),
        .crc_err_o(crc_err_o), .end_err_o(end_err_o), .index_err_o(index_err_o)
    );

    always #5 clk_i = ~clk_i;
    assign errs = {timeout_err_o, crc_err_o, end_err_o, index_err_o};

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rtype;
        int           delay;      // start bit driven in cycle 48+delay; <0 means silent card
        logic [5:0]   r_idx;
        logic [119:0] r_body;
        logic [6:0]   crc_flip;
        logic         force_7f;
        logic         end_bit;
        logic [47:0]  exp_frame;
        logic [119:0] exp_resp;
        logic [3:0]   exp_errs;   // {timeout, crc, end, index}
        int           exp_done;
    } vec_t;

    typedef struct {
        logic [47:0]  frame;
        logic [119:0] resp;
        logic [3:0]   errs;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tv[12];

    // CRC7 as remainder of the augmented message divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_calc(input logic [135:0] d, input int n);
        logic [7:0] r;
        logic       b;
        r = 8'h00;
        for (int i = n - 1; i >= -7; i--) begin
            b = (i >= 0) ? d[i] : 1'b0;
            r = {r[6:0], b};
            if (r[7]) r = r ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] b;
        b = {2'b01, idx, arg};
        return {b, crc7_calc({96'h0, b}, 40), 1'b1};
    endfunction

    function automatic logic [47:0] mk_r48(input logic [5:0] r_idx, input logic [31:0] arg,
                                           input logic [6:0] flip, input logic f7f, input logic eb);
        logic [39:0] b;
        logic [6:0]  c;
        b = {2'b00, r_idx, arg};
        c = f7f ? 7'h7F : (crc7_calc({96'h0, b}, 40) ^ flip);
        return {b, c, eb};
    endfunction

    function automatic vec_t mkv(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                                 input int delay, input logic [5:0] r_idx, input logic [119:0] r_body,
                                 input logic [6:0] flip, input logic f7f, input logic eb,
                                 input logic [119:0] exp_resp, input logic [3:0] exp_errs, input int exp_done);
        vec_t v;
        v.idx = idx; v.arg = arg; v.rtype = rtype; v.delay = delay;
        v.r_idx = r_idx; v.r_body = r_body; v.crc_flip = flip; v.force_7f = f7f; v.end_bit = eb;
        v.exp_frame = mk_frame(idx, arg);
        v.exp_resp = exp_resp; v.exp_errs = exp_errs; v.exp_done = exp_done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [119:0] act, input logic [119:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        exp_t         e;
        logic [135:0] rf;
        int           n, s, nen, first_en, nbusy, done_cyc;
        logic [47:0]  sent;
        bit           got;
        if (v.rtype == 2'b10) begin
            n  = 136;
            rf = {2'b00, v.r_idx, v.r_body, crc7_calc({16'h0, v.r_body}, 120) ^ v.crc_flip, v.end_bit};
        end else begin
            n  = 48;
            rf = {88'h0, mk_r48(v.r_idx, v.r_body[31:0], v.crc_flip, v.force_7f, v.end_bit)};
        end
        e.frame = v.exp_frame; e.resp = v.exp_resp; e.errs = v.exp_errs; e.done_cyc = v.exp_done;
        tick();
        start_i = 1'b1; cmd_index_i = v.idx; cmd_arg_i = v.arg; resp_type_i = v.rtype;
        sb.push_back(e);
        tick();
        start_i = 1'b0;
        cmd_index_i = 6'($urandom); cmd_arg_i = $urandom; resp_type_i = 2'($urandom);
        s = 48 + v.delay;
        sent = '0; nen = 0; first_en = 0; nbusy = 0; done_cyc = 0; got = 1'b0;
        for (int cyc = 1; cyc <= 400 && !got; cyc++) begin
            if (v.delay >= 0 && cyc >= s && cyc < s + n) cmd_i = rf[n - 1 - (cyc - s)];
            else                                         cmd_i = 1'b1;
            @(negedge clk_i);
            if (cmd_en_o) begin
                sent = {sent[46:0], cmd_o};
                nen++;
                if (first_en == 0) first_en = cyc;
            end
            if (busy_o) nbusy++;
            if (done_o) begin
                got = 1'b1;
                done_cyc = cyc;
            end else begin
                tick();
            end
        end
        cmd_i = 1'b1;
        chk($sformatf("vec%0d done seen", id), 120'(got), 120'(1));
        chk($sformatf("vec%0d sb depth", id), 120'(sb.size()), 120'(1));
        if (sb.size() != 0) e = sb.pop_front();
        if (!got) begin
            abort_i = 1'b1;
            tick();
            abort_i = 1'b0;
            return;
        end
        chk($sformatf("vec%0d frame", id), 120'(sent), 120'(e.frame));
        chk($sformatf("vec%0d tx cycles", id), 120'(nen), 120'(48));
        chk($sformatf("vec%0d tx first", id), 120'(first_en), 120'(1));
        chk($sformatf("vec%0d done cycle", id), 120'(done_cyc), 120'(e.done_cyc));
        chk($sformatf("vec%0d busy cycles", id), 120'(nbusy), 120'(e.done_cyc - 1));
        chk($sformatf("vec%0d resp", id), resp_o, e.resp);
        chk($sformatf("vec%0d errs", id), 120'(errs), 120'(e.errs));
        tick();
        @(negedge clk_i);
        chk($sformatf("vec%0d done pulse", id), 120'({done_o, busy_o}), 120'(2'b00));
        tick(); tick();
        @(negedge clk_i);
        chk($sformatf("vec%0d errs held", id), 120'(errs), 120'(e.errs));
        chk($sformatf("vec%0d resp held", id), resp_o, e.resp);
    endtask

    localparam logic [119:0] CID = 120'h0353_4453_4443_3830_1012_3456_7801_4A;

    initial begin
        int          n_done, n_act;
        logic [47:0] r7;
        rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; cmd_i = 1'b1;
        cmd_index_i = 6'd0; cmd_arg_i = 32'h0; resp_type_i = 2'b00;

        tv[0]  = mkv(6'd0,  32'h0,        2'b00, -1, 6'd0,  120'h0,        7'h00, 1'b0, 1'b1, 120'h0,        4'b0000, 57);
        tv[0].exp_frame = 48'h4000_0000_0095;
        tv[1]  = mkv(6'd8,  32'h1AA,      2'b01,  5, 6'd8,  120'h1AA,      7'h00, 1'b0, 1'b1, 120'h1AA,      4'b0000, 109);
        tv[2]  = mkv(6'd8,  32'h1AA,      2'b01,  5, 6'd8,  120'h1AA,      7'h10, 1'b0, 1'b1, 120'h1AA,      4'b0100, 109);
        tv[3]  = mkv(6'd8,  32'h1AA,      2'b01,  5, 6'd9,  120'h1AA,      7'h00, 1'b0, 1'b1, 120'h1AA,      4'b0001, 109);
        tv[4]  = mkv(6'd8,  32'h1AA,      2'b01,  5, 6'd8,  120'h1AA,      7'h00, 1'b0, 1'b0, 120'h1AA,      4'b0010, 109);
        tv[5]  = mkv(6'd8,  32'h1AA,      2'b01, -1, 6'd8,  120'h1AA,      7'h00, 1'b0, 1'b1, 120'h0,        4'b1000, 113);
        tv[6]  = mkv(6'd8,  32'h1AA,      2'b01, 64, 6'd8,  120'h1AA,      7'h00, 1'b0, 1'b1, 120'h1AA,      4'b0000, 168);
        tv[7]  = mkv(6'd8,  32'h1AA,      2'b01, 65, 6'd8,  120'h1AA,      7'h00, 1'b0, 1'b1, 120'h0,        4'b1000, 113);
        tv[8]  = mkv(6'd41, 32'h40FF8000, 2'b11,  2, 6'h3F, 120'h80FF8000, 7'h00, 1'b1, 1'b1, 120'h80FF8000, 4'b0000, 106);
        tv[9]  = mkv(6'd2,  32'h0,        2'b10,  3, 6'h3F, CID,           7'h00, 1'b0, 1'b1, CID,           4'b0000, 195);
        tv[10] = mkv(6'd55, 32'hA5A50F0F, 2'b01,  1, 6'd55, 120'h3C3C3C3C, 7'h41, 1'b0, 1'b0, 120'h3C3C3C3C, 4'b0110, 105);
        tv[11] = mkv(6'd7,  32'hDEADBEEF, 2'b00, -1, 6'd0,  120'h0,        7'h00, 1'b0, 1'b1, 120'h0,        4'b0000, 57);

        repeat (2) @(negedge clk_i);
        chk("reset outputs", 120'({cmd_en_o, cmd_o, busy_o, done_o, errs}), 120'(8'b0100_0000));
        chk("reset resp", resp_o, 120'h0);
        rst_ni = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 12; i++) run_vec(tv[i], i);

        // abort in TX cycle 20
        tick();
        start_i = 1'b1; cmd_index_i = 6'd17; cmd_arg_i = 32'h12345678; resp_type_i = 2'b01;
        tick();
        start_i = 1'b0;
        repeat (19) tick();
        abort_i = 1'b1;
        @(negedge clk_i);
        chk("abort pre", 120'({cmd_en_o, busy_o}), 120'(2'b11));
        tick();
        abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort idle", 120'({cmd_en_o, cmd_o, busy_o, done_o}), 120'(4'b0100));
        chk("abort errs", 120'(errs), 120'(4'b0000));
        tick();
        start_i = 1'b1; abort_i = 1'b1;
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        n_done = 0; n_act = 0;
        repeat (120) begin
            @(negedge clk_i);
            if (done_o) n_done++;
            if (busy_o || cmd_en_o) n_act++;
            tick();
        end
        chk("abort no done", 120'(n_done), 120'(0));
        chk("abort wins over start", 120'(n_act), 120'(0));

        // reset asserted while receiving response bit 10
        r7 = mk_r48(6'd8, 32'h1AA, 7'h00, 1'b0, 1'b1);
        start_i = 1'b1; cmd_index_i = 6'd8; cmd_arg_i = 32'h1AA; resp_type_i = 2'b01;
        tick();
        start_i = 1'b0;
        for (int cyc = 1; cyc < 63; cyc++) begin
            cmd_i = (cyc >= 53) ? r7[47 - (cyc - 53)] : 1'b1;
            if (cyc == 62) begin
                @(negedge clk_i);
                chk("rx busy before reset", 120'({busy_o, cmd_en_o}), 120'(2'b10));
            end
            tick();
        end
        rst_ni = 1'b0;
        #1;
        chk("reset mid-rx", 120'({cmd_en_o, cmd_o, busy_o, done_o, errs}), 120'(8'b0100_0000));
        chk("reset mid-rx resp", resp_o, 120'h0);
        cmd_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        n_done = 0; n_act = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (done_o) n_done++;
            if (busy_o || cmd_en_o) n_act++;
        end
        chk("reset no done", 120'(n_done), 120'(0));
        chk("reset stays idle", 120'(n_act), 120'(0));
        run_vec(tv[1], 12);

        // start_i held during the DONE cycle must not launch a new command
        tick();
        start_i = 1'b1; cmd_index_i = 6'd0; cmd_arg_i = 32'h0; resp_type_i = 2'b00;
        tick();
        start_i = 1'b0;
        repeat (56) tick();
        start_i = 1'b1; cmd_index_i = 6'd5; resp_type_i = 2'b01;
        @(negedge clk_i);
        chk("done at cycle 57", 120'({done_o, busy_o}), 120'(2'b10));
        tick();
        start_i = 1'b0;
        n_act = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (busy_o || cmd_en_o || done_o) n_act++;
            tick();
        end
        chk("start in DONE ignored", 120'(n_act), 120'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
